// File: rtl/mrr_header_tx_if.sv
// mrr_header_tx_if
//   Sample stream carrying the framed MRR uplink waveform.
//   Signals:
//     o_tdata  ESAMP_WIDTH  sample value
//     o_tvalid 1            sample valid
//     o_tready 1            downstream ready
//     o_tlast  1            last sample of the frame
//     o_tkeep  1            byte keep, always 1 while o_tvalid
//   Modports: master (the transmitter), slave (the sink).
interface mrr_header_tx_if #(
    parameter int ESAMP_WIDTH = 16
);
    logic [ESAMP_WIDTH-1:0] o_tdata;
    logic                   o_tvalid;
    logic                   o_tready;
    logic                   o_tlast;
    logic                   o_tkeep;

    modport master (
        output o_tdata,
        output o_tvalid,
        output o_tlast,
        output o_tkeep,
        input  o_tready
    );

    modport slave (
        input  o_tdata,
        input  o_tvalid,
        input  o_tlast,
        input  o_tkeep,
        output o_tready
    );
endinterface

// File: rtl/mrr_header_tx.sv
// mrr_header_tx
//   Transmit side of the MRR header correlator. On start it emits one frame:
//   an optional run of lead_gap zero samples, HEADER_PULSES header symbols
//   (all pulses), then the PN_LEN-bit PN sequence MSB first. Each symbol
//   lasts P = (recharge_len+2) << OVERSAMPLING_RATIO_LOG2 samples; a '0'
//   symbol starts with 2^OVERSAMPLING_RATIO_LOG2 samples of pulse_amp, a '1'
//   symbol is all zeros.
//   Optional build macro MRR_HEADER_TX_JITTER_EN: each symbol length is
//   perturbed by +/-max_jitter, chosen by a 16-bit Fibonacci LFSR stepped at
//   every symbol start and reseeded on every accepted start.
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     start            1-cycle frame request (ignored while busy)
//     recharge_len     symbol spacing, sampled at start
//     lead_gap         zero samples before the header, sampled at start
//     pulse_amp        pulse sample value, sampled at start
//     max_jitter       symbol length deviation (jitter build only)
//     tx_if            sample stream (master modport)
//     busy             frame in progress
//     done             1-cycle pulse after the final handshake
//
//   state    | meaning
//   S_IDLE   | waiting for start, outputs quiet
//   S_LEAD   | sending lead_gap zero samples
//   S_HEADER | sending header pulse symbols
//   S_PN     | sending PN symbols, index PN_LEN-1 down to 0
//   S_DONE   | one-cycle done pulse, back to idle
module mrr_header_tx #(
    parameter int                ESAMP_WIDTH             = 16,
    parameter int                OVERSAMPLING_RATIO_LOG2 = 2,
    parameter int                HEADER_PULSES           = 16,
    parameter int                PN_LEN                  = 15,
    parameter logic [PN_LEN-1:0] PN_SEQ                  = 15'b000100110101111,
    parameter logic [15:0]       LFSR_SEED               = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [14:0]            recharge_len,
    input  logic [15:0]            lead_gap,
    input  logic [ESAMP_WIDTH-1:0] pulse_amp,
    input  logic [7:0]             max_jitter,
    mrr_header_tx_if.master        tx_if,
    output logic                   busy,
    output logic                   done
);

    localparam int SAMP_W = 18;
    localparam int SYM_W  = 5;
    localparam logic [SAMP_W-1:0] PULSE_SAMPS = SAMP_W'(1 << OVERSAMPLING_RATIO_LOG2);
    localparam logic [SYM_W-1:0]  HDR_LAST    = SYM_W'(HEADER_PULSES - 1);
    localparam logic [SYM_W-1:0]  PN_LAST     = SYM_W'(PN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_HEADER,
        S_PN,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [SAMP_W-1:0]      samp_q, samp_d;
    logic [SYM_W-1:0]       sym_q, sym_d;
    logic [14:0]            rlen_q, rlen_d;
    logic [15:0]            lead_q, lead_d;
    logic [ESAMP_WIDTH-1:0] amp_q, amp_d;

    logic              fire;
    logic              start_acc;
    logic              start_sym;
    logic [SAMP_W-1:0] period;
    logic [SAMP_W-1:0] sym_len;
    logic              last_samp;
    logic [PN_LEN-1:0] pn_shifted;
    logic              pn_bit;

    assign fire       = tx_if.o_tvalid & tx_if.o_tready;
    assign period     = (SAMP_W'(rlen_q) + SAMP_W'(2)) << OVERSAMPLING_RATIO_LOG2;
    assign last_samp  = (samp_q == sym_len - SAMP_W'(1));
    // Shift rather than index so the 5-bit symbol counter needs no trimming.
    assign pn_shifted = PN_SEQ >> sym_q;
    assign pn_bit     = pn_shifted[0];

`ifdef MRR_HEADER_TX_JITTER_EN
    logic [7:0]  mj_q, mj_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  jsel_q, jsel_d;
    logic [15:0] lfsr_base;
    logic [15:0] lfsr_nx;

    // jsel holds the LFSR low bits captured when the current symbol began.
    always_comb begin
        sym_len = period;
        case (jsel_q)
            2'b01:   sym_len = period + SAMP_W'(mj_q);
            2'b10:   sym_len = period - SAMP_W'(mj_q);
            default: sym_len = period;
        endcase
    end

    // The first symbol of a frame steps from the seed even when it starts
    // in the same cycle as the reseed (start with lead_gap = 0).
    always_comb begin
        mj_d      = mj_q;
        lfsr_d    = lfsr_q;
        jsel_d    = jsel_q;
        lfsr_base = (state_q == S_IDLE) ? LFSR_SEED : lfsr_q;
        lfsr_nx   = {lfsr_base[0] ^ lfsr_base[2] ^ lfsr_base[3] ^ lfsr_base[5],
                     lfsr_base[15:1]};
        if (start_acc) begin
            mj_d   = max_jitter;
            lfsr_d = LFSR_SEED;
        end
        if (start_sym) begin
            lfsr_d = lfsr_nx;
            jsel_d = lfsr_nx[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mj_q   <= '0;
            lfsr_q <= LFSR_SEED;
            jsel_q <= '0;
        end else begin
            mj_q   <= mj_d;
            lfsr_q <= lfsr_d;
            jsel_q <= jsel_d;
        end
    end
`else
    logic unused_jitter;
    assign sym_len       = period;
    assign unused_jitter = ^{max_jitter, start_acc, start_sym};
`endif

    always_comb begin
        state_d   = state_q;
        samp_d    = samp_q;
        sym_d     = sym_q;
        rlen_d    = rlen_q;
        lead_d    = lead_q;
        amp_d     = amp_q;
        start_acc = 1'b0;
        start_sym = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    rlen_d    = recharge_len;
                    lead_d    = lead_gap;
                    amp_d     = pulse_amp;
                    samp_d    = '0;
                    sym_d     = '0;
                    if (lead_gap == 16'd0) begin
                        state_d   = S_HEADER;
                        start_sym = 1'b1;
                    end else begin
                        state_d = S_LEAD;
                    end
                end
            end
            S_LEAD: begin
                if (fire) begin
                    if (samp_q == SAMP_W'(lead_q) - SAMP_W'(1)) begin
                        state_d   = S_HEADER;
                        samp_d    = '0;
                        sym_d     = '0;
                        start_sym = 1'b1;
                    end else begin
                        samp_d = samp_q + SAMP_W'(1);
                    end
                end
            end
            S_HEADER: begin
                if (fire) begin
                    if (last_samp) begin
                        samp_d    = '0;
                        start_sym = 1'b1;
                        if (sym_q == HDR_LAST) begin
                            state_d = S_PN;
                            sym_d   = PN_LAST;
                        end else begin
                            sym_d = sym_q + SYM_W'(1);
                        end
                    end else begin
                        samp_d = samp_q + SAMP_W'(1);
                    end
                end
            end
            S_PN: begin
                if (fire) begin
                    if (last_samp) begin
                        samp_d = '0;
                        if (sym_q == '0) begin
                            state_d = S_DONE;
                        end else begin
                            sym_d     = sym_q - SYM_W'(1);
                            start_sym = 1'b1;
                        end
                    end else begin
                        samp_d = samp_q + SAMP_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state, so they hold while stalled.
    always_comb begin
        tx_if.o_tvalid = 1'b0;
        tx_if.o_tdata  = '0;
        tx_if.o_tlast  = 1'b0;
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        case (state_q)
            S_LEAD: begin
                tx_if.o_tvalid = 1'b1;
            end
            S_HEADER: begin
                tx_if.o_tvalid = 1'b1;
                if (samp_q < PULSE_SAMPS) tx_if.o_tdata = amp_q;
            end
            S_PN: begin
                tx_if.o_tvalid = 1'b1;
                if (!pn_bit && samp_q < PULSE_SAMPS) tx_if.o_tdata = amp_q;
                tx_if.o_tlast  = (sym_q == '0) && last_samp;
            end
            default: begin
                tx_if.o_tvalid = 1'b0;
            end
        endcase
        tx_if.o_tkeep = tx_if.o_tvalid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            samp_q  <= '0;
            sym_q   <= '0;
            rlen_q  <= '0;
            lead_q  <= '0;
            amp_q   <= '0;
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            sym_q   <= sym_d;
            rlen_q  <= rlen_d;
            lead_q  <= lead_d;
            amp_q   <= amp_d;
        end
    end

endmodule

// File: tb/tb_mrr_header_tx.sv
// tb_mrr_header_tx
//   Self-checking bench for mrr_header_tx. A frame-level model builds the
//   full expected sample list (lead zeros, header pulses, PN symbols with
//   per-symbol lengths) and one compare process checks every accepted sample,
//   stall stability, busy/done behaviour and idle quietness after done.
//   Honours MRR_HEADER_TX_JITTER_EN the same way the design does.
module tb_mrr_header_tx;

    localparam logic [15:0] SEED   = 16'hACE1;
    localparam logic [14:0] PN_VAL = 15'b000100110101111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [14:0] recharge_len = '0;
    logic [15:0] lead_gap = '0;
    logic [15:0] pulse_amp = '0;
    logic [7:0]  max_jitter = '0;
    logic        busy;
    logic        done;
    logic        tready_drv = 1'b1;

    mrr_header_tx_if #(.ESAMP_WIDTH(16)) tx_if ();
    assign tx_if.o_tready = tready_drv;

    mrr_header_tx dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .recharge_len (recharge_len),
        .lead_gap     (lead_gap),
        .pulse_amp    (pulse_amp),
        .max_jitter   (max_jitter),
        .tx_if        (tx_if),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_data[$];
    logic        exp_last[$];
    int          sym_lens[$];
    int          idx = 0;
    int          done_cnt = 0;
    bit          chk_en = 1'b0;
    bit          done_seen = 1'b0;
    bit          stall_prev = 1'b0;
    bit          last_fire_prev = 1'b0;
    logic [15:0] held_data = '0;
    logic        held_last = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t idx=%0d)", name, act, exp, $time, idx);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Expected frame: list of (sample, last) pairs from the symbol rules.
    task automatic build_exp(input int lead, input int rlen, input int amp, input int mj);
        int          p;
        int          len;
        logic [15:0] lf;
        logic        bitv;
        logic [14:0] pn;
        pn = PN_VAL;
        p  = (rlen + 2) * 4;
        lf = SEED;
        exp_data.delete();
        exp_last.delete();
        sym_lens.delete();
        for (int i = 0; i < lead; i++) begin
            exp_data.push_back(16'd0);
            exp_last.push_back(1'b0);
        end
        for (int s = 0; s < 31; s++) begin
            bitv = (s < 16) ? 1'b0 : pn[14 - (s - 16)];
            len  = p;
`ifdef MRR_HEADER_TX_JITTER_EN
            lf = lfsr_next(lf);
            if (lf[1:0] == 2'b01) len = p + mj;
            else if (lf[1:0] == 2'b10) len = p - mj;
`else
            if (mj < 0) len = p;
`endif
            sym_lens.push_back(len);
            for (int k = 0; k < len; k++) begin
                exp_data.push_back((bitv == 1'b0 && k < 4) ? 16'(amp) : 16'd0);
                exp_last.push_back(s == 30 && k == len - 1);
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (!done_seen) begin
                chk("valid_in_frame", tx_if.o_tvalid | done, 1);
                chk("busy_in_frame", busy, 1);
            end
            if (tx_if.o_tvalid) begin
                chk("tkeep", tx_if.o_tkeep, 1);
                if (stall_prev) begin
                    chk("stall_data", tx_if.o_tdata, held_data);
                    chk("stall_last", tx_if.o_tlast, held_last);
                end
                if (tx_if.o_tready) begin
                    if (idx < exp_data.size()) begin
                        chk("data", tx_if.o_tdata, exp_data[idx]);
                        chk("tlast", tx_if.o_tlast, exp_last[idx]);
                    end else begin
                        chk("extra_sample", idx, exp_data.size());
                    end
                    idx++;
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_after_tlast", last_fire_prev, 1);
                chk("done_sample_count", idx, exp_data.size());
                chk("done_tvalid_low", tx_if.o_tvalid, 0);
                done_seen = 1'b1;
            end else if (done_seen) begin
                chk("idle_busy", busy, 0);
                chk("idle_tvalid", tx_if.o_tvalid, 0);
            end
            stall_prev     = tx_if.o_tvalid & ~tx_if.o_tready;
            held_data      = tx_if.o_tdata;
            held_last      = tx_if.o_tlast;
            last_fire_prev = tx_if.o_tvalid & tx_if.o_tready & tx_if.o_tlast;
        end
    end

    task automatic run_frame(input int lead, input int rlen, input int amp, input int mj,
                             input bit rand_ready, input int abort_at, input int restart_at);
        int cyc;
        bit restarted;
        bit aborted;
        build_exp(lead, rlen, amp, mj);
        @(posedge clk); #1;
        lead_gap     = 16'(lead);
        recharge_len = 15'(rlen);
        pulse_amp    = 16'(amp);
        max_jitter   = 8'(mj);
        start        = 1'b1;
        tready_drv   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        idx = 0; done_cnt = 0; done_seen = 1'b0;
        stall_prev = 1'b0; last_fire_prev = 1'b0;
        @(posedge clk); #1;
        start  = 1'b0;
        chk_en = 1'b1;
        // Config changes after acceptance must not affect this frame.
        lead_gap = 16'd9; recharge_len = 15'd7; pulse_amp = 16'h5555; max_jitter = 8'd0;
        cyc = 0; restarted = 1'b0; aborted = 1'b0;
        while (!done_seen && cyc < 20000 && !aborted) begin
            tready_drv = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start = 1'b0;
            if (restart_at >= 0 && !restarted && idx >= restart_at) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (abort_at >= 0 && idx >= abort_at) begin
                aborted = 1'b1;
                chk_en  = 1'b0;
                rst     = 1'b1;
                start   = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (abort_at >= 0) begin
            chk("abort_reached", aborted, 1);
            chk("abort_tvalid", tx_if.o_tvalid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_tlast", tx_if.o_tlast, 0);
            chk("abort_tdata", tx_if.o_tdata, 0);
            rst = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                chk("abort_quiet", {done, tx_if.o_tvalid}, 0);
            end
        end else begin
            chk("frame_finished", done_seen, 1);
            repeat (6) @(posedge clk);
            #1;
            chk("done_once", done_cnt, 1);
        end
        chk_en = 1'b0;
        tready_drv = 1'b1;
    endtask

    initial begin
        logic [15:0] lf;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", tx_if.o_tvalid, 0);
        chk("rst_tlast", tx_if.o_tlast, 0);
        chk("rst_tkeep", tx_if.o_tkeep, 0);
        chk("rst_tdata", tx_if.o_tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        // Pin the model against hand-computed values.
        build_exp(0, 2, 100, 0);
        chk("model_len", exp_data.size(), 496);
        chk("model_s0", exp_data[0], 100);
        chk("model_s3", exp_data[3], 100);
        chk("model_s4", exp_data[4], 0);
        chk("model_pn3", exp_data[304], 0);
        chk("model_pn4", exp_data[320], 100);
        chk("model_last495", exp_last[495], 1);
        chk("model_last494", exp_last[494], 0);
        lf = lfsr_next(SEED); chk("lfsr1", lf, 16'h5670);
        lf = lfsr_next(lf);   chk("lfsr2", lf, 16'hAB38);
        lf = lfsr_next(lf);   chk("lfsr3", lf, 16'h559C);
        lf = lfsr_next(lf);   chk("lfsr4", lf, 16'h2ACE);
        lf = lfsr_next(lf);   chk("lfsr5", lf, 16'h1567);
        build_exp(5, 2, 100, 0);
        chk("model_lead_len", exp_data.size(), 501);
        chk("model_lead_s4", exp_data[4], 0);
        chk("model_lead_s5", exp_data[5], 100);
        chk("model_lead_last", exp_last[500], 1);

        run_frame(0, 2, 100, 0, 1'b0, -1, -1);
        run_frame(0, 2, 100, 0, 1'b1, -1, -1);
        run_frame(5, 2, 100, 0, 1'b0, -1, -1);
        run_frame(0, 2, 100, 0, 1'b0, 7 * 16, -1);
        run_frame(0, 2, 100, 0, 1'b0, -1, -1);
        run_frame(0, 2, 100, 0, 1'b1, -1, 100);
        run_frame(3, 5, 16'h1234, 0, 1'b1, -1, -1);

`ifdef MRR_HEADER_TX_JITTER_EN
        build_exp(0, 2, 100, 2);
        chk("jit_len0", sym_lens[0], 16);
        chk("jit_len1", sym_lens[1], 16);
        chk("jit_len2", sym_lens[2], 16);
        chk("jit_len3", sym_lens[3], 14);
        chk("jit_len4", sym_lens[4], 16);
        foreach (sym_lens[i])
            chk("jit_len_set", (sym_lens[i] == 14 || sym_lens[i] == 16 || sym_lens[i] == 18), 1);
        run_frame(0, 2, 100, 2, 1'b0, -1, -1);
        run_frame(0, 2, 100, 2, 1'b1, -1, -1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
